// File: rtl/hazard_pkg.sv
// Shared constants for the RV32I hazard scoreboard: forwarding-mux select codes
// and the default producer latencies of the execute-side units.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters: load on issue, age by one every cycle,
// three combinational read ports and an any-pending reduction.
module sb_counter_bank #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [REG_AW-1:0] load_addr,
  input  logic [LAT_W-1:0]  load_val,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  input  logic [REG_AW-1:0] rd_addr_c,
  output logic [LAT_W-1:0]  rd_cnt_a,
  output logic [LAT_W-1:0]  rd_cnt_b,
  output logic [LAT_W-1:0]  rd_cnt_c,
  output logic              busy
);

  // x0 has no storage at all; reads of it return zero.
  logic [LAT_W-1:0] cnt [1:NUM_REGS-1];

  // NOTE: this array is cleared on reset because it is control state (pending
  // hazards), not data; stale counts would produce phantom stalls after reset.
  // NOTE: sequential state uses non-blocking assignments so every counter sees
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (load_en && load_addr == REG_AW'(r))
          cnt[r] <= load_val;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  function automatic logic [LAT_W-1:0] read_cnt(input logic [REG_AW-1:0] addr);
    read_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++)
      if (addr == REG_AW'(r)) read_cnt = cnt[r];
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) busy = busy | (cnt[r] != '0);
  end

  assign rd_cnt_a = read_cnt(rd_addr_a);
  assign rd_cnt_b = read_cnt(rd_addr_b);
  assign rd_cnt_c = read_cnt(rd_addr_c);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit for the 5-stage RV32I pipeline: scoreboarded RAW/WAW
// stalls for variable-latency producers, branch flushes and M/W forwarding.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 4,
  parameter int LAT_W    = 3,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic [LAT_W-1:0]  lat_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_w,
  input  logic              pcsrc_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              busy,
  output logic [PERF_W-1:0] stall_count
);

  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic             bank_busy;
  logic             raw, waw, hazard_stall, issue;

  always_comb begin
    if (lat_d == '0)
      lat_eff = LAT_W'(1);
    else if (lat_d > LAT_W'(MAX_LAT))
      lat_eff = LAT_W'(MAX_LAT);
    else
      lat_eff = lat_d;
  end

  // A count of 1 means the producer reaches M/W as the consumer reaches E,
  // so only counts above 1 need a stall.
  assign raw = issue_valid_d &
               (((rs1_d != '0) & (cnt_rs1 > LAT_W'(1))) |
                ((rs2_d != '0) & (cnt_rs2 > LAT_W'(1))));
  assign waw = issue_valid_d & regwrite_d & (rd_d != '0) & (cnt_rd > lat_eff);

  assign hazard_stall = (raw | waw) & ~pcsrc_e & ~rst;
  assign issue        = issue_valid_d & regwrite_d & (rd_d != '0) &
                        ~hazard_stall & ~pcsrc_e;

  sb_counter_bank #(
    .REG_AW   (REG_AW),
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .load_en   (issue),
    .load_addr (rd_d),
    .load_val  (lat_eff),
    .rd_addr_a (rs1_d),
    .rd_addr_b (rs2_d),
    .rd_addr_c (rd_d),
    .rd_cnt_a  (cnt_rs1),
    .rd_cnt_b  (cnt_rs2),
    .rd_cnt_c  (cnt_rd),
    .busy      (bank_busy)
  );

  assign stall_f = hazard_stall;
  assign stall_d = hazard_stall;
  assign flush_d = pcsrc_e | rst;
  assign flush_e = pcsrc_e | hazard_stall | rst;
  assign busy    = bank_busy & ~rst;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    if (m_we && m_rd != '0 && m_rd == rs)
      fwd_sel = FWD_M;
    else if (w_we && w_rd != '0 && w_rd == rs)
      fwd_sel = FWD_W;
    else
      fwd_sel = FWD_REG;
  endfunction

  assign forward_a_e = rst ? FWD_REG : fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
  assign forward_b_e = rst ? FWD_REG : fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);

  // Saturating so long runs report "at least this many" rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (hazard_stall && stall_count != '1)
      stall_count <= stall_count + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: expected output vectors are queued as
// each cycle's stimulus is driven and compared when sampled on the falling edge.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic        clk, rst;
  logic        issue_valid_d, regwrite_d, regwrite_m, regwrite_w, pcsrc_e;
  logic [4:0]  rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_m, rd_w;
  logic [2:0]  lat_d;
  logic        stall_f, stall_d, flush_d, flush_e, busy;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [31:0] stall_count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_stalls;
  logic [8:0]  exp_q[$];

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic [4:0] rs1, rs2, rd;
    logic       rw;
    logic [2:0] lat;
    logic       pc;
    logic [4:0] rs1e, rs2e, rdm;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww;
  } row_t;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid_d(issue_valid_d), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d), .lat_d(lat_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .pcsrc_e(pcsrc_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .busy(busy),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t dec(logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               logic rw, logic [2:0] lat, logic pc);
    row_t t = '0;
    t.iv = iv; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.lat = lat; t.pc = pc;
    return t;
  endfunction

  function automatic row_t erow(logic [4:0] rs1e, logic [4:0] rs2e, logic [4:0] rdm,
                                logic rwm, logic [4:0] rdw, logic rww);
    row_t t = '0;
    t.rs1e = rs1e; t.rs2e = rs2e; t.rdm = rdm; t.rwm = rwm; t.rdw = rdw; t.rww = rww;
    return t;
  endfunction

  // {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e}
  function automatic logic [8:0] ex(logic st, logic fd, logic fe, logic bz,
                                    logic [1:0] fa, logic [1:0] fb);
    return {st, st, fd, fe, bz, fa, fb};
  endfunction

  task automatic apply(input row_t t);
    rst = t.rst; issue_valid_d = t.iv; rs1_d = t.rs1; rs2_d = t.rs2; rd_d = t.rd;
    regwrite_d = t.rw; lat_d = t.lat; pcsrc_e = t.pc; rs1_e = t.rs1e; rs2_e = t.rs2e;
    rd_m = t.rdm; regwrite_m = t.rwm; rd_w = t.rdw; regwrite_w = t.rww;
  endtask

  task automatic test_reset();
    row_t r[$]; logic [8:0] x[$]; row_t t; logic [8:0] got, want;
    t = erow(3, 4, 3, 1, 4, 1); t.rst = 1; t.iv = 1; t.rd = 5; t.rw = 1; t.lat = 2;
    r.push_back(t); x.push_back(ex(0, 1, 1, 0, FWD_REG, FWD_REG));
    r.push_back(erow(3, 4, 3, 1, 4, 1)); x.push_back(ex(0, 0, 0, 0, FWD_M, FWD_W));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL reset[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL reset[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t r[$]; logic [8:0] x[$]; logic [8:0] got, want;
    r.push_back(dec(1, 0, 0, 5, 1, 2, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    r.push_back(dec(1, 5, 0, 6, 1, 1, 0)); x.push_back(ex(1, 0, 1, 1, FWD_REG, FWD_REG));
    r.push_back(dec(1, 5, 0, 6, 1, 1, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(erow(5, 0, 5, 1, 0, 0));   x.push_back(ex(0, 0, 0, 1, FWD_M, FWD_REG));
    r.push_back(erow(5, 0, 6, 1, 5, 1));   x.push_back(ex(0, 0, 0, 0, FWD_W, FWD_REG));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL load_use[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL load_use[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_back_to_back();
    row_t r[$]; logic [8:0] x[$]; logic [8:0] got, want;
    r.push_back(dec(1, 0, 0, 3, 1, 1, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    r.push_back(dec(1, 0, 3, 4, 1, 1, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(erow(0, 3, 3, 1, 0, 0));   x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_M));
    r.push_back(erow(0, 3, 4, 1, 3, 1));   x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_W));
    r.push_back(erow(3, 3, 3, 1, 3, 1));   x.push_back(ex(0, 0, 0, 0, FWD_M, FWD_M));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL alu_b2b[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL alu_b2b[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_cycle_raw();
    row_t r[$]; logic [8:0] x[$]; logic [8:0] got, want;
    r.push_back(dec(1, 0, 0, 7, 1, 4, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int k = 0; k < 3; k++) begin
      r.push_back(dec(1, 7, 0, 8, 0, 1, 0)); x.push_back(ex(1, 0, 1, 1, FWD_REG, FWD_REG));
    end
    r.push_back(dec(1, 7, 0, 8, 0, 1, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(dec(0, 0, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL multi_raw[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL multi_raw[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waw_x0();
    row_t r[$]; logic [8:0] x[$]; row_t t; logic [8:0] got, want;
    r.push_back(dec(1, 0, 0, 9, 1, 4, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int k = 0; k < 3; k++) begin
      r.push_back(dec(1, 0, 0, 9, 1, 1, 0)); x.push_back(ex(1, 0, 1, 1, FWD_REG, FWD_REG));
    end
    r.push_back(dec(1, 0, 0, 9, 1, 1, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(dec(1, 0, 0, 0, 1, 4, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    t = dec(1, 0, 0, 0, 1, 3, 0); t.rwm = 1; t.rww = 1;
    r.push_back(t);                        x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    // Equal latency to the pending write is not a WAW hazard.
    r.push_back(dec(1, 0, 0, 9, 1, 4, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    r.push_back(dec(1, 0, 0, 9, 1, 4, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    for (int k = 0; k < 4; k++) begin
      r.push_back(dec(0, 0, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    end
    r.push_back(dec(0, 0, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL waw_x0[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL waw_x0[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lat_clamp();
    row_t r[$]; logic [8:0] x[$]; logic [8:0] got, want;
    r.push_back(dec(1, 0, 0, 10, 1, 7, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int k = 0; k < 3; k++) begin
      r.push_back(dec(1, 10, 0, 11, 1, 0, 0)); x.push_back(ex(1, 0, 1, 1, FWD_REG, FWD_REG));
    end
    r.push_back(dec(1, 10, 0, 11, 1, 0, 0)); x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(dec(1, 0, 11, 0, 0, 0, 0));  x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(dec(0, 0, 0, 0, 0, 0, 0));   x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL lat_clamp[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL lat_clamp[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_override();
    row_t r[$]; logic [8:0] x[$]; logic [8:0] got, want;
    r.push_back(dec(1, 0, 0, 12, 1, 4, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    r.push_back(dec(1, 12, 0, 13, 1, 2, 0)); x.push_back(ex(1, 0, 1, 1, FWD_REG, FWD_REG));
    r.push_back(dec(1, 12, 0, 13, 1, 2, 1)); x.push_back(ex(0, 1, 1, 1, FWD_REG, FWD_REG));
    r.push_back(dec(1, 13, 0, 0, 0, 0, 0));  x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(dec(0, 0, 0, 0, 0, 0, 0));   x.push_back(ex(0, 0, 0, 1, FWD_REG, FWD_REG));
    r.push_back(dec(0, 0, 0, 0, 0, 0, 0));   x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL branch[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL branch[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    row_t r[$]; logic [8:0] x[$]; row_t t; logic [8:0] got, want;
    r.push_back(dec(1, 0, 0, 7, 1, 4, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    r.push_back(dec(1, 7, 0, 0, 0, 0, 0)); x.push_back(ex(1, 0, 1, 1, FWD_REG, FWD_REG));
    t = dec(1, 7, 0, 0, 0, 0, 0); t.rst = 1;
    r.push_back(t);                        x.push_back(ex(0, 1, 1, 0, FWD_REG, FWD_REG));
    r.push_back(dec(1, 7, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, FWD_REG, FWD_REG));
    for (int i = 0; i < r.size(); i++) begin
      apply(r[i]); exp_q.push_back(x[i]);
      @(negedge clk);
      got = {stall_f, stall_d, flush_d, flush_e, busy, forward_a_e, forward_b_e};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL reset_mid[%0d] outputs got=%b want=%b", i, got, want); end
      checks++;
      if (stall_count !== exp_stalls) begin errors++; $display("FAIL reset_mid[%0d] stall_count got=%0d want=%0d", i, stall_count, exp_stalls); end
      if (r[i].rst) exp_stalls = '0; else if (want[7] && exp_stalls != '1) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    row_t t;
    t = '0; t.rst = 1'b1;
    apply(t);
    exp_stalls = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_back_to_back();
    test_multi_cycle_raw();
    test_waw_x0();
    test_lat_clamp();
    test_branch_override();
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (stall_count !== exp_stalls) begin
      errors++;
      $display("FAIL final stall_count got=%0d want=%0d", stall_count, exp_stalls);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed forwarding-only hazard unit of the 5-stage RV32I pipeline.
- Adds a per-register pending-write scoreboard, so execute-side producers with variable latency are tracked. Examples: ALU=1, load=2, multi-cycle MUL up to MAX_LAT.
- Generates decode stalls (RAW and WAW), branch flushes, and M/W forwarding selects.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the decode and execute stages and drives fetch/decode stall and decode/execute flush.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, architectural registers; x0 is hardwired and never tracked.
- MAX_LAT, 4, largest producer latency in cycles, from execute entry until the result is forwardable.
- LAT_W, 3, width of the latency field and of each scoreboard counter; must hold MAX_LAT.
- PERF_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid_d  in  1  decode stage holds a valid instruction
- rs1_d  in  REG_AW  decode source 1
- rs2_d  in  REG_AW  decode source 2
- rd_d  in  REG_AW  decode destination
- regwrite_d  in  1  decode instruction writes rd
- lat_d  in  LAT_W  producer latency of the decode instruction
- rs1_e  in  REG_AW  execute source 1
- rs2_e  in  REG_AW  execute source 2
- rd_m  in  REG_AW  memory-stage destination
- regwrite_m  in  1  memory-stage write enable
- rd_w  in  REG_AW  writeback-stage destination
- regwrite_w  in  1  writeback-stage write enable
- pcsrc_e  in  1  taken branch/jump resolved in execute
- stall_f  out  1  hold PC
- stall_d  out  1  hold fetch/decode register
- flush_d  out  1  clear fetch/decode register
- flush_e  out  1  insert bubble into decode/execute register
- forward_a_e  out  2  operand A select: 00 regfile, 10 M result, 01 W result
- forward_b_e  out  2  operand B select, same encoding as forward_a_e
- busy  out  1  at least one scoreboard counter is nonzero
- stall_count  out  PERF_W  cycles in which stall_d was asserted

Behaviour:
- Reset behaviour: clk rising edge with rst=1 clears all counters and stall_count. While rst=1, combinational outputs are forced: stall_f/stall_d=0, flush_d/flush_e=1, forward selects=00, busy=0.
- Scoreboard: cnt[r], LAT_W bits, for r=1..NUM_REGS-1. cnt[0] is always 0. cnt[r] is the number of cycles until r's pending value is forwardable to the execute stage.
- Per-cycle update:
  - Every nonzero cnt decrements by 1.
  - On issue, cnt[rd_d] is loaded with lat_eff instead of decrementing; issue wins over decrement.
  - issue = issue_valid_d & regwrite_d & (rd_d!=0) & ~stall_d & ~pcsrc_e.
  - lat_eff = clamp(lat_d, 1, MAX_LAT): lat_d=0 is treated as 1, values above MAX_LAT as MAX_LAT.
- RAW hazard: raw = issue_valid_d & ((rs1_d!=0 & cnt[rs1_d]>1) | (rs2_d!=0 & cnt[rs2_d]>1)).
  - cnt<=1 means the value reaches M or W by the time the instruction is in E, so forwarding covers it.
- WAW hazard: waw = issue_valid_d & regwrite_d & rd_d!=0 & cnt[rd_d] > lat_eff. This prevents out-of-order completion to the same register.
- Stall: stall_d = stall_f = (raw|waw) & ~pcsrc_e. A taken branch overrides the stall because the decode instruction is discarded.
- Flush: flush_d = pcsrc_e; flush_e = pcsrc_e | stall_d. A stall inserts a bubble into execute.
- Forwarding (combinational, per operand X in {1,2}):
  - 10 if regwrite_m & rd_m!=0 & rd_m==rsX_e.
  - Else 01 if regwrite_w & rd_w!=0 & rd_w==rsX_e.
  - Else 00.
  - M has priority over W.
- Execute/memory/writeback never stall, so counters age every cycle regardless of stall_d.
- stall_count increments on each cycle with stall_d=1 and saturates at all-ones; no wrap.
- busy = OR of all cnt.
- Reset mid-operation: pending entries are discarded immediately; the next cycle reports no hazards.

Decomposition:
- Shared package hazard_pkg holds the forward-select constants (FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10) and the default latencies LAT_ALU=1, LAT_LOAD=2, LAT_MUL=4.
- One natural sub-module, sb_counter_bank: the NUM_REGS counter array with load, decrement, read ports, and busy reduction.
- Hazard, flush and forwarding logic remain in hazard_scoreboard.

Test Plan:
- Load-use: issue rd=5, lat=2; next cycle decode rs1=5 -> stall_d=1 and flush_e=1 for exactly 1 cycle; then issue; when that instruction reaches E with rd_m=5, regwrite_m=1 -> forward_a_e=10; stall_count=1.
- ALU back-to-back: issue rd=3, lat=1; next cycle rs2_d=3 -> no stall; in E with rd_m=3 -> forward_b_e=10; with rd_w=3 only -> 01.
- Multi-cycle RAW: issue rd=7, lat=4; dependent rs1=7 follows immediately -> stall_d high for 3 cycles, then released; busy high for 4 cycles.
- WAW plus x0: issue rd=9, lat=4, then rd=9, lat=1 -> stall until cnt[9]<=1. Instructions with rd=0 or rs=0 never stall and never forward; forward selects stay 00.
- Branch override: pcsrc_e=1 while a RAW stall is active -> stall_d=0, flush_d=1, flush_e=1, no scoreboard load for that cycle.
- Reset mid-operation: assert rst with cnt[7]=3 -> next cycle busy=0, stall_count=0; a dependent instruction on rs1=7 issues without stall.
